// File: rtl/out_display_ctrl.sv
// SAP1 output display: double-dabble BCD conversion of the output register value,
// then leading-zero-blanked, time-multiplexed drive of a 7-segment display.
module out_display_ctrl #(
  parameter int WIDTH    = 8,
  parameter int DIGITS   = 3,
  parameter int SCAN_DIV = 1024
) (
  input  logic              mclk,
  input  logic              rst_n,
  input  logic [WIDTH-1:0]  i_data,
  output logic [6:0]        o_seg,
  output logic [DIGITS-1:0] o_an,
  output logic              o_busy
);

  // Decimal digits of 2^WIDTH-1 is floor(WIDTH*log10(2))+1 since 2^WIDTH is never a power of ten.
  localparam int MIN_DIGITS = (WIDTH * 30103) / 100000 + 1;
  localparam int BCD_W      = 4 * DIGITS;
  localparam int CNT_W      = $clog2(WIDTH + 1);
  localparam int SCAN_W     = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IDX_W      = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  generate
    if (DIGITS < MIN_DIGITS) begin : g_bad_digits
      $error("out_display_ctrl: DIGITS too small for WIDTH");
    end
    if (SCAN_DIV < 1) begin : g_bad_scan_div
      $error("out_display_ctrl: SCAN_DIV must be >= 1");
    end
  endgenerate

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CONV = 2'd1,
    ST_LOAD = 2'd2
  } state_t;

  state_t             state;
  state_t             state_nx;
  logic [WIDTH-1:0]   last_data;
  logic [WIDTH-1:0]   bin_sr;
  logic [BCD_W-1:0]   bcd_acc;
  logic [BCD_W-1:0]   disp;
  logic [CNT_W-1:0]   bit_cnt;
  logic [SCAN_W-1:0]  scan_cnt;
  logic [IDX_W-1:0]   idx;

  logic [BCD_W-1:0]   bcd_adj;
  logic [BCD_W-1:0]   bcd_step;
  logic [WIDTH-1:0]   bin_step;
  logic [SCAN_W-1:0]  scan_nx;
  logic [IDX_W-1:0]   idx_nx;
  logic [6:0]         seg_nx;
  logic               nz;

  function automatic logic [6:0] encode(input logic [3:0] d);
    case (d)
      4'd0:    encode = 7'h3F;
      4'd1:    encode = 7'h06;
      4'd2:    encode = 7'h5B;
      4'd3:    encode = 7'h4F;
      4'd4:    encode = 7'h66;
      4'd5:    encode = 7'h6D;
      4'd6:    encode = 7'h7D;
      4'd7:    encode = 7'h07;
      4'd8:    encode = 7'h7F;
      4'd9:    encode = 7'h6F;
      default: encode = 7'h00;
    endcase
  endfunction

  // One double-dabble step: add 3 to every nibble >= 5, then shift {bcd, bin} left.
  always_comb begin
    bcd_adj = bcd_acc;
    for (int k = 0; k < DIGITS; k++) begin
      if (bcd_acc[4*k +: 4] >= 4'd5) bcd_adj[4*k +: 4] = bcd_acc[4*k +: 4] + 4'd3;
    end
    {bcd_step, bin_step} = {bcd_adj, bin_sr} << 1;
  end

  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE: if (i_data != last_data) state_nx = ST_CONV;
      ST_CONV: if (bit_cnt == CNT_W'(WIDTH - 1)) state_nx = ST_LOAD;
      ST_LOAD: state_nx = ST_IDLE;
      default: state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge mclk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nx;
  end

  always_ff @(posedge mclk or negedge rst_n) begin
    if (!rst_n) begin
      last_data <= '0;
      bin_sr    <= '0;
      bcd_acc   <= '0;
      disp      <= '0;
      bit_cnt   <= '0;
      o_busy    <= 1'b0;
    end else begin
      o_busy <= (state_nx != ST_IDLE);
      case (state)
        ST_IDLE: begin
          if (state_nx == ST_CONV) begin
            last_data <= i_data;
            bin_sr    <= i_data;
            bcd_acc   <= '0;
            bit_cnt   <= '0;
          end
        end
        ST_CONV: begin
          bcd_acc <= bcd_step;
          bin_sr  <= bin_step;
          bit_cnt <= bit_cnt + 1'b1;
        end
        ST_LOAD: disp <= bcd_acc;
        default: ;
      endcase
    end
  end

  always_comb begin
    scan_nx = scan_cnt + 1'b1;
    idx_nx  = idx;
    if (scan_cnt == SCAN_W'(SCAN_DIV - 1)) begin
      scan_nx = '0;
      idx_nx  = (idx == IDX_W'(DIGITS - 1)) ? '0 : idx + 1'b1;
    end
  end

  // Walk from the top digit down so nz tells whether this digit or any above is non-zero.
  always_comb begin
    nz     = 1'b0;
    seg_nx = 7'h00;
    for (int k = DIGITS - 1; k >= 0; k--) begin
      nz = nz | (disp[4*k +: 4] != 4'd0);
      if (IDX_W'(k) == idx_nx) seg_nx = ((k == 0) || nz) ? encode(disp[4*k +: 4]) : 7'h00;
    end
  end

  always_ff @(posedge mclk or negedge rst_n) begin
    if (!rst_n) begin
      scan_cnt <= '0;
      idx      <= '0;
      o_an     <= DIGITS'(1);
      o_seg    <= 7'h3F;
    end else begin
      scan_cnt <= scan_nx;
      idx      <= idx_nx;
      o_an     <= DIGITS'(1) << idx_nx;
      o_seg    <= seg_nx;
    end
  end

endmodule

// File: tb/tb_out_display_ctrl.sv
// Bench for out_display_ctrl: per-cycle comparison against a behavioural model of
// conversion latency, scan position and decimal display, plus literal spot checks.
module tb_out_display_ctrl;

  localparam int WIDTH    = 8;
  localparam int DIGITS   = 3;
  localparam int SCAN_DIV = 4;

  // Clock/reset block
  logic              mclk = 1'b0;
  logic              rst_n;
  logic [WIDTH-1:0]  i_data;
  logic [6:0]        o_seg;
  logic [DIGITS-1:0] o_an;
  logic              o_busy;

  always #5 mclk = ~mclk;

  out_display_ctrl #(.WIDTH(WIDTH), .DIGITS(DIGITS), .SCAN_DIV(SCAN_DIV)) dut (
    .mclk   (mclk),
    .rst_n  (rst_n),
    .i_data (i_data),
    .o_seg  (o_seg),
    .o_an   (o_an),
    .o_busy (o_busy)
  );

  int checks   = 0;
  int failures = 0;
  logic chk_en = 1'b0;

  logic [6:0] seg_tbl [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                               7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // Expected segments for decimal digit k of value v, with leading-zero blanking.
  function automatic logic [6:0] seg_of(input int v, input int k);
    int p = 1;
    for (int i = 0; i < k; i++) p = p * 10;
    if (k > 0 && v < p) return 7'h00;
    return seg_tbl[(v / p) % 10];
  endfunction

  // Behavioural model: a captured value reaches the display WIDTH+1 edges later.
  logic [WIDTH-1:0] exp_q[$];
  int unsigned      n_edges;
  logic [WIDTH-1:0] last;
  int               conv_left;
  int               disp_val;
  logic [6:0]       exp_seg;
  logic [DIGITS-1:0] exp_an;
  logic             exp_busy;

  always @(posedge mclk or negedge rst_n) begin
    if (!rst_n) begin
      n_edges   = 0;
      last      = '0;
      conv_left = 0;
      disp_val  = 0;
      exp_q.delete();
      exp_an    = DIGITS'(1);
      exp_seg   = 7'h3F;
      exp_busy  = 1'b0;
    end else begin
      int pos;
      n_edges++;
      pos     = int'((n_edges / SCAN_DIV) % DIGITS);
      exp_an  = DIGITS'(1 << pos);
      exp_seg = seg_of(disp_val, pos);
      if (conv_left > 0) begin
        conv_left--;
        if (conv_left == 0) disp_val = int'(exp_q.pop_front());
      end else if (i_data != last) begin
        last = i_data;
        exp_q.push_back(i_data);
        conv_left = WIDTH + 1;
      end
      exp_busy = (conv_left > 0);
    end
  end

  // Scoreboard compare on the falling edge, away from the active edge.
  always @(negedge mclk) begin
    if (chk_en) begin
      check("seg", o_seg, exp_seg);
      check("an", o_an, exp_an);
      check("busy", o_busy, exp_busy);
      check("an_onehot", $onehot(o_an), 1);
    end
  end

  // Driver tasks
  task automatic tick(input int n);
    repeat (n) @(negedge mclk);
  endtask

  task automatic scan_read(output logic [DIGITS-1:0][6:0] s);
    s = '0;
    repeat (DIGITS * SCAN_DIV) begin
      @(negedge mclk);
      for (int k = 0; k < DIGITS; k++) if (o_an[k]) s[k] = o_seg;
    end
  endtask

  task automatic reset_pulse(input int low_cycles);
    @(negedge mclk);
    #2 rst_n = 1'b0;
    tick(low_cycles);
    #2 rst_n = 1'b1;
  endtask

  logic [DIGITS-1:0][6:0] s;
  int busy_hi;
  int pulses;
  logic prev_busy;

  initial begin
    rst_n  = 1'b1;
    i_data = '0;
    #1 rst_n = 1'b0;
    chk_en = 1'b1;
    tick(3);
    check("rst_busy", o_busy, 0);
    check("rst_an", o_an, 3'b001);
    check("rst_seg", o_seg, 7'h3F);
    #2 rst_n = 1'b1;

    // Pin the model's digit arithmetic with hand-computed values.
    check("pin_255_d0", seg_of(255, 0), 7'h6D);
    check("pin_255_d2", seg_of(255, 2), 7'h5B);
    check("pin_7_d1", seg_of(7, 1), 7'h00);
    check("pin_100_d1", seg_of(100, 1), 7'h3F);
    check("pin_42_d2", seg_of(42, 2), 7'h00);

    tick(20);
    scan_read(s);
    check("zero_d0", s[0], 7'h3F);
    check("zero_d1", s[1], 7'h00);
    check("zero_d2", s[2], 7'h00);

    i_data  = 8'd255;
    busy_hi = 0;
    repeat (12) begin
      @(negedge mclk);
      if (o_busy) busy_hi++;
    end
    check("busy_len", busy_hi, WIDTH + 1);
    scan_read(s);
    check("d255_0", s[0], 7'h6D);
    check("d255_1", s[1], 7'h6D);
    check("d255_2", s[2], 7'h5B);

    i_data = 8'd7;
    tick(12);
    scan_read(s);
    check("d7_0", s[0], 7'h07);
    check("d7_1", s[1], 7'h00);
    check("d7_2", s[2], 7'h00);

    i_data = 8'd100;
    tick(12);
    scan_read(s);
    check("d100_0", s[0], 7'h3F);
    check("d100_1", s[1], 7'h3F);
    check("d100_2", s[2], 7'h06);

    i_data = 8'd5;
    tick(12);
    i_data    = 8'd200;
    pulses    = 0;
    prev_busy = 1'b0;
    for (int i = 0; i < 28; i++) begin
      @(negedge mclk);
      if (o_busy && !prev_busy) pulses++;
      prev_busy = o_busy;
      if (i == 2) i_data = 8'd42;
    end
    check("b2b_pulses", pulses, 2);
    scan_read(s);
    check("d42_0", s[0], 7'h5B);
    check("d42_1", s[1], 7'h66);
    check("d42_2", s[2], 7'h00);

    i_data = 8'd0;
    tick(12);
    i_data = 8'd99;
    tick(4);
    #2 rst_n = 1'b0;
    tick(3);
    check("midrst_busy", o_busy, 0);
    check("midrst_an", o_an, 3'b001);
    check("midrst_seg", o_seg, 7'h3F);
    #2 rst_n = 1'b1;
    tick(14);
    scan_read(s);
    check("d99_0", s[0], 7'h6F);
    check("d99_1", s[1], 7'h6F);
    check("d99_2", s[2], 7'h00);

    for (int v = 0; v < 256; v++) begin
      i_data = WIDTH'(v);
      tick(12);
    end

    repeat (300) begin
      i_data = WIDTH'($urandom_range(0, 255));
      tick($urandom_range(1, 14));
      if ($urandom_range(0, 24) == 0) reset_pulse($urandom_range(1, 3));
    end
    tick(30);

    chk_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
